multi_port_relay: RTL and testbench

N-channel buffered byte relay: each channel accepts a byte stream on `rxd`/`rx_dv` and re-emits it in order on `txd`/`tx_en`. A per-channel FIFO absorbs stalls from a downstream `tx_rdy`. Overflow drops are counted per channel. It replaces the fixed two-channel register-through stage as the environment's DUT and keeps the same per-channel rx/tx signalling.

---
 rtl/relay_pkg.sv | 22 ++
 rtl/relay_fifo.sv | 60 ++++++
 rtl/multi_port_relay.sv | 73 +++++++
 tb/tb_multi_port_relay.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared defaults, the channel byte type and the pointer-width helper for the
// multi-channel byte relay.
package relay_pkg;

  localparam int RELAY_NCH   = 2;
  localparam int RELAY_DW    = 8;
  localparam int RELAY_DEPTH = 16;
  localparam int RELAY_CNT_W = 16;

  typedef logic [RELAY_DW-1:0] relay_byte_t;

  // Number of address bits needed to index a power-of-two FIFO of this depth.
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/relay_fifo.sv
// Single-channel synchronous FIFO: array storage, registered read data that
// holds between pops, and a registered full flag.
module relay_fifo
  import relay_pkg::*;
#(
  parameter int DW    = RELAY_DW,
  parameter int DEPTH = RELAY_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = clog2_depth(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_reg;
  logic          full_reg, full_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    full_next = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      dout_reg   <= '0;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      if (pop) dout_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign dout  = dout_reg;
  assign full  = full_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/multi_port_relay.sv
// N-channel buffered byte relay: one FIFO per channel plus output strobe and
// drop counter. Drop counters exist only when MULTI_PORT_RELAY_DROP_CNT_EN is defined.
module multi_port_relay
  import relay_pkg::*;
#(
  parameter int NCH   = RELAY_NCH,
  parameter int DW    = RELAY_DW,
  parameter int DEPTH = RELAY_DEPTH,
  parameter int CNT_W = RELAY_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*DW-1:0]    rxd,
  input  logic [NCH-1:0]       rx_dv,
  output logic [NCH*DW-1:0]    txd,
  output logic [NCH-1:0]       tx_en,
  input  logic [NCH-1:0]       tx_rdy,
  output logic [NCH*CNT_W-1:0] drop_cnt,
  output logic [NCH-1:0]       full
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic pop, push, empty, full_w;
      logic tx_en_reg;

      // A full FIFO still takes the byte when the head leaves on the same edge.
      assign pop  = tx_rdy[gi] && !empty;
      assign push = rx_dv[gi] && (!full_w || pop);

      relay_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (rxd[gi*DW +: DW]),
        .pop   (pop),
        .dout  (txd[gi*DW +: DW]),
        .full  (full_w),
        .empty (empty)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_en_reg <= 1'b0;
        else        tx_en_reg <= pop;
      end

      assign tx_en[gi] = tx_en_reg;
      assign full[gi]  = full_w;

`ifdef MULTI_PORT_RELAY_DROP_CNT_EN
      logic             drop;
      logic [CNT_W-1:0] drop_cnt_reg;

      assign drop = rx_dv[gi] && full_w && !pop;

      // Saturates rather than wrapping so a long overflow never reads as few drops.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt_reg <= '0;
        else if (drop && drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end

      assign drop_cnt[gi*CNT_W +: CNT_W] = drop_cnt_reg;
`else
      assign drop_cnt[gi*CNT_W +: CNT_W] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_relay.sv
// Directed bench for multi_port_relay: a queue scoreboard per channel, plus a
// small second instance with a 4-bit drop counter for saturation.
module tb_multi_port_relay;
  import relay_pkg::*;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
`ifdef MULTI_PORT_RELAY_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NCH*DW-1:0]    rxd;
  logic [NCH-1:0]       rx_dv, tx_rdy, tx_en, full;
  logic [NCH*DW-1:0]    txd;
  logic [NCH*CNT_W-1:0] drop_cnt;

  logic [DW-1:0] s_rxd, s_txd;
  logic [0:0]    s_dv, s_rdy, s_en, s_full;
  logic [3:0]    s_cnt;

  int checks = 0;
  int passed = 0;

  relay_byte_t sb [NCH][$];
  int          occ [NCH];
  int          drops [NCH];
  relay_byte_t last_txd [NCH];

  always #5 clk = ~clk;

  multi_port_relay #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_dv    (rx_dv),
    .txd      (txd),
    .tx_en    (tx_en),
    .tx_rdy   (tx_rdy),
    .drop_cnt (drop_cnt),
    .full     (full)
  );

  multi_port_relay #(.NCH(1), .DW(DW), .DEPTH(2), .CNT_W(4)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (s_rxd),
    .rx_dv    (s_dv),
    .txd      (s_txd),
    .tx_en    (s_en),
    .tx_rdy   (s_rdy),
    .drop_cnt (s_cnt),
    .full     (s_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      sb[c].delete();
      occ[c] = 0;
      drops[c] = 0;
      last_txd[c] = '0;
    end
  endtask

  // Drive one cycle of inputs, advance one edge, and compare against the model.
  task automatic cycle(input logic [NCH-1:0] dv, input logic [NCH*DW-1:0] d,
                       input logic [NCH-1:0] rdy);
    logic [NCH-1:0] exp_en;
    relay_byte_t    exp_d;
    rx_dv = dv; rxd = d; tx_rdy = rdy;
    for (int c = 0; c < NCH; c++) begin
      exp_en[c] = rdy[c] && (occ[c] > 0);
      if (dv[c]) begin
        if (occ[c] < DEPTH || exp_en[c]) begin
          sb[c].push_back(d[c*DW +: DW]);
          occ[c]++;
        end else begin
          drops[c]++;
        end
      end
      if (exp_en[c]) occ[c]--;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("tx_en[%0d]", c), 32'(tx_en[c]), 32'(exp_en[c]));
      if (exp_en[c]) begin
        if (sb[c].size() > 0) begin
          exp_d = sb[c].pop_front();
          last_txd[c] = exp_d;
        end
      end
      check($sformatf("txd[%0d]", c), 32'(txd[c*DW +: DW]), 32'(last_txd[c]));
      check($sformatf("full[%0d]", c), 32'(full[c]), 32'(occ[c] == DEPTH));
      check($sformatf("drop_cnt[%0d]", c), 32'(drop_cnt[c*CNT_W +: CNT_W]),
            CNT_EN ? 32'(drops[c]) : 32'd0);
    end
  endtask

  initial begin
    rx_dv = '0; rxd = '0; tx_rdy = '0;
    s_dv = '0; s_rxd = '0; s_rdy = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset txd", 32'(txd), 32'd0);
    check("reset tx_en", 32'(tx_en), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    check("reset sat_cnt", 32'(s_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Pass-through on both channels, then drain.
    for (int i = 0; i < 16; i++)
      cycle(2'b11, {8'(8'hF0 + i), 8'(8'h01 + i)}, 2'b11);
    repeat (3) cycle(2'b00, '0, 2'b11);

    // Fill ch0, overflow by 5, simultaneous push/pop on full, then drain.
    for (int i = 0; i < 16; i++) cycle(2'b01, {8'h00, 8'(i)}, 2'b10);
    for (int i = 0; i < 5; i++)  cycle(2'b01, {8'h00, 8'(8'h50 + i)}, 2'b10);
    cycle(2'b01, {8'h00, 8'hAA}, 2'b11);
    repeat (18) cycle(2'b00, '0, 2'b11);

    // Saturating drop counter on the 2-deep, 4-bit-counter instance.
    s_rdy = 1'b0;
    for (int i = 0; i < 22; i++) begin
      s_dv = 1'b1; s_rxd = 8'(i);
      cycle(2'b00, '0, 2'b11);
      if (i == 11) check("sat drop_cnt 10", 32'(s_cnt), CNT_EN ? 32'd10 : 32'd0);
    end
    check("sat drop_cnt 15", 32'(s_cnt), CNT_EN ? 32'd15 : 32'd0);
    check("sat full", 32'(s_full), 32'd1);
    s_dv = 1'b0;

    // Mid-stream asynchronous reset with 7 entries held in ch1.
    for (int i = 0; i < 7; i++) cycle(2'b10, {8'(8'h30 + i), 8'h00}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async txd", 32'(txd), 32'd0);
    check("async tx_en", 32'(tx_en), 32'd0);
    check("async full", 32'(full), 32'd0);
    check("async drop_cnt", 32'(drop_cnt), 32'd0);
    check("async sat_cnt", 32'(s_cnt), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) cycle(2'b00, '0, 2'b11);

    // Short burst after release to show the first edge accepts data.
    for (int i = 0; i < 4; i++)
      cycle(2'b11, {8'(8'hC0 + i), 8'(8'h60 + i)}, 2'b11);
    repeat (3) cycle(2'b00, '0, 2'b11);
    for (int c = 0; c < NCH; c++)
      check($sformatf("scoreboard empty[%0d]", c), 32'(sb[c].size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
